// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//   Byte-addressed data memory for the single-cycle RISC-V core. Handles
//   LB/LH/LW/LBU/LHU loads (combinational) and SB/SH/SW stores (synchronous,
//   byte-lane masked). After reset a sequential sweep zeroes every word.
//   Alignment, range and funct3 legality are checked, and the first bad
//   access is recorded in a sticky fault register.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   addr       : byte address
//   re / we    : load / store request
//   funct3     : access size and sign mode
//   wd         : store data (low byte/half used for SB/SH)
//   rd         : load data, sign/zero extended
//   busy       : clear sweep in progress
//   misaligned : alignment violation on the current access (combinational)
//   fault      : sticky error flag
//   fault_addr : address of the first faulting access
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DEPTH_WORDS    = 256,
    parameter int ADDR_WIDTH     = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  re,
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [31:0]           wd,
    output logic [31:0]           rd,
    output logic                  busy,
    output logic                  misaligned,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] fault_addr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {CLEAR, READY} state_t;

    state_t           state;
    logic [IDX_W-1:0] clr_idx;
    logic [31:0]      mem [DEPTH_WORDS];

    // ---------------- decode ----------------
    logic [IDX_W-1:0] widx;
    logic [1:0]       lane;
    logic             acc, is_half, is_word;
    logic             ld_illegal, st_illegal, oob, err, store_en;

    assign widx    = addr[IDX_W+1:2];
    assign lane    = addr[1:0];
    assign acc     = re | we;
    assign is_half = (funct3[1:0] == 2'b01);
    assign is_word = (funct3 == 3'b010);

    // Loads reject 011/110/111; stores only accept 000/001/010.
    assign ld_illegal = re & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11));
    assign st_illegal = we & (funct3[2] | (funct3[1:0] == 2'b11));

    assign oob        = (addr >> 2) >= ADDR_WIDTH'(DEPTH_WORDS);
    assign misaligned = acc & ((is_half & addr[0]) | (is_word & (|addr[1:0])));
    assign err        = acc & (misaligned | oob | ld_illegal | st_illegal);
    assign busy       = (state == CLEAR);
    assign store_en   = we & ~busy & ~err;

    // ---------------- load path ----------------
    logic [31:0] rd_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        rd_word  = mem[widx];
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = rd_word[{addr[1], 4'b0000} +: 16];
        rd       = '0;
        if (re & ~busy & ~err) begin
            case (funct3)
                3'b000:  rd = {{24{byte_sel[7]}}, byte_sel};
                3'b100:  rd = {24'b0, byte_sel};
                3'b001:  rd = {{16{half_sel[15]}}, half_sel};
                3'b101:  rd = {16'b0, half_sel};
                3'b010:  rd = rd_word;
                default: rd = '0;
            endcase
        end
    end

    // ---------------- store lane steering ----------------
    logic [3:0]  be;
    logic [31:0] wdata;

    always_comb begin
        be    = '0;
        wdata = '0;
        case (funct3)
            3'b000: begin
                be    = 4'b0001 << lane;
                wdata = {4{wd[7:0]}};
            end
            3'b001: begin
                be    = 4'b0011 << {addr[1], 1'b0};
                wdata = {2{wd[15:0]}};
            end
            3'b010: begin
                be    = 4'b1111;
                wdata = wd;
            end
            default: ;
        endcase
    end

    // Array has no reset; writes are gated on rst so nothing commits while
    // reset is held (the sweep then starts cleanly at index 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            if (busy) begin
                mem[clr_idx] <= '0;
            end else if (store_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- control FSM + fault record ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if (CLEAR_ON_RESET) state <= CLEAR;
            else                state <= READY;
            clr_idx    <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) state <= READY;
                end
                READY: begin
                    // First error wins; later ones leave the record intact.
                    if (err && !fault) begin
                        fault      <= 1'b1;
                        fault_addr <= addr;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl : self-checking bench for data_mem_ctrl (DEPTH_WORDS=16).
// Expected load data is queued when the access is driven and popped when rd
// is sampled. Inputs change on the falling edge, outputs are sampled 2ns
// later, stores commit on the following rising edge.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int DW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          re = 1'b0;
    logic          we = 1'b0;
    logic [2:0]    funct3 = 3'b000;
    logic [31:0]   wd = '0;
    logic [31:0]   rd;
    logic          busy;
    logic          misaligned;
    logic          fault;
    logic [AW-1:0] fault_addr;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    data_mem_ctrl #(.DEPTH_WORDS(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .funct3(funct3),
        .wd(wd), .rd(rd), .busy(busy), .misaligned(misaligned), .fault(fault),
        .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        re = r; we = w; funct3 = f; addr = a; wd = d;
    endtask

    task automatic idle();
        re = 1'b0; we = 1'b0; addr = '0; wd = '0; funct3 = 3'b000;
    endtask

    // One store, committed on the next rising edge.
    task automatic store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); drive(1'b0, 1'b1, f, a, d);
        @(negedge clk); idle();
    endtask

    // Release reset and count falling edges with busy high.
    task automatic release_and_count(output int cyc);
        @(negedge clk); rst = 1'b1;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cyc;
        logic [31:0] got, exp;
        logic [31:0] la [2];
        la[0] = 32'h3C; la[1] = 32'h00;
        rst = 1'b0;
        dut.mem[0] = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got=%b exp=1", busy); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", fault); end
        n_cmp++; if (fault_addr !== '0) begin n_err++; $display("FAIL reset_fault_addr got=%h exp=0", fault_addr); end
        release_and_count(cyc);
        n_cmp++; if (cyc !== DW) begin n_err++; $display("FAIL clear_cycles got=%0d exp=%0d", cyc, DW); end
        for (int i = 0; i < 2; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(1'b1, 1'b0, 3'b010, la[i], '0);
            #2 got = rd; exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL clear_lw@%h got=%h exp=%h", la[i], got, exp); end
        end
        idle();
    endtask

    task automatic test_load_ext();
        logic [31:0] got, exp;
        logic [31:0] la [5];
        logic [2:0]  lf [5];
        logic [31:0] le [5];
        la = '{32'h10, 32'h11, 32'h12, 32'h10, 32'h10};
        lf = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        le = '{32'hFFFF_FFF0, 32'h0000_0080, 32'hFFFF_8000, 32'h0000_80F0, 32'h8000_80F0};
        store(3'b010, 32'h10, 32'h8000_80F0);
        for (int i = 0; i < 5; i++) exp_q.push_back(le[i]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(1'b1, 1'b0, lf[i], la[i], '0);
            #2 got = rd; exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL ld_ext%0d@%h f3=%b got=%h exp=%h", i, la[i], lf[i], got, exp); end
        end
        idle();
    endtask

    task automatic test_partial_store();
        logic [31:0] got, exp;
        logic [31:0] la [2];
        la[0] = 32'h10; la[1] = 32'h14;
        store(3'b000, 32'h13, 32'h1234_56AB);
        store(3'b001, 32'h14, 32'h0000_BEEF);
        exp_q.push_back(32'hAB00_80F0);
        exp_q.push_back(32'h0000_BEEF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(1'b1, 1'b0, 3'b010, la[i], '0);
            #2 got = rd; exp = exp_q.pop_front();
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL partial_lw@%h got=%h exp=%h", la[i], got, exp); end
        end
        idle();
    endtask

    // Read and write the same word in one cycle: old data now, new data next.
    task automatic test_back_to_back();
        logic [31:0] got, exp;
        store(3'b010, 32'h18, 32'hCAFE_0001);
        exp_q.push_back(32'hCAFE_0001);
        exp_q.push_back(32'h1357_9BDF);
        @(negedge clk); drive(1'b1, 1'b1, 3'b010, 32'h18, 32'h1357_9BDF);
        #2 got = rd; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rw_same_old got=%h exp=%h", got, exp); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h18, '0);
        #2 got = rd; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rw_same_new got=%h exp=%h", got, exp); end
        idle();
    endtask

    task automatic test_misaligned();
        logic [31:0] got, exp;
        store(3'b010, 32'h20, 32'h1122_3344);
        @(negedge clk); drive(1'b0, 1'b1, 3'b010, 32'h22, 32'hDEAD_BEEF);
        #2;
        n_cmp++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL sw22_misaligned got=%b exp=1", misaligned); end
        @(negedge clk); idle();
        n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL sw22_fault got=%b exp=1", fault); end
        n_cmp++; if (fault_addr !== 32'h22) begin n_err++; $display("FAIL sw22_fault_addr got=%h exp=22", fault_addr); end
        exp_q.push_back(32'h1122_3344);
        exp_q.push_back(32'h0);
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h20, '0);
        #2 got = rd; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL sw22_nowrite got=%h exp=%h", got, exp); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b001, 32'h31, '0);
        #2 got = rd; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL lh31_rd got=%h exp=%h", got, exp); end
        n_cmp++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL lh31_misaligned got=%b exp=1", misaligned); end
        @(negedge clk); idle();
        n_cmp++; if (fault_addr !== 32'h22) begin n_err++; $display("FAIL sticky_fault_addr got=%h exp=22", fault_addr); end
    endtask

    task automatic test_oob_illegal();
        int cyc;
        logic [31:0] got, exp;
        @(negedge clk); rst = 1'b0;
        release_and_count(cyc);
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL oob_pre_fault got=%b exp=0", fault); end
        store(3'b010, 32'h40, 32'h5A5A_5A5A);
        n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL oob_fault got=%b exp=1", fault); end
        n_cmp++; if (fault_addr !== 32'h40) begin n_err++; $display("FAIL oob_fault_addr got=%h exp=40", fault_addr); end
        store(3'b010, 32'h10, 32'h7777_8888);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h7777_8888);
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h00, '0);
        #2 got = rd; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL oob_nowrap got=%h exp=%h", got, exp); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b011, 32'h10, '0);
        #2 got = rd; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL f3_011_rd got=%h exp=%h", got, exp); end
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h10, '0);
        #2 got = rd; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL f3_legal_rd got=%h exp=%h", got, exp); end
        idle();
        n_cmp++; if (fault_addr !== 32'h40) begin n_err++; $display("FAIL oob_sticky got=%h exp=40", fault_addr); end
    endtask

    task automatic test_clear_interaction();
        int cyc;
        logic [31:0] got, exp;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        drive(1'b1, 1'b1, 3'b010, 32'h00, 32'h0000_0055);
        #2;
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL busy_rd got=%h exp=0", rd); end
        @(negedge clk); drive(1'b0, 1'b1, 3'b010, 32'h02, 32'h0000_0055);
        #2;
        n_cmp++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL busy_misaligned got=%b exp=1", misaligned); end
        @(negedge clk); idle();
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL busy_fault got=%b exp=0", fault); end
        cyc = 0;
        while (busy && cyc < 100) begin cyc++; @(negedge clk); end
        exp_q.push_back(32'h0);
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h00, '0);
        #2 got = rd; exp = exp_q.pop_front();
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL busy_store_dropped got=%h exp=%h", got, exp); end
        idle();
        // Reset pulse in the middle of the sweep restarts it from index 0.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        release_and_count(cyc);
        n_cmp++; if (cyc !== DW) begin n_err++; $display("FAIL midclear_cycles got=%0d exp=%0d", cyc, DW); end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_partial_store();
        test_back_to_back();
        test_misaligned();
        test_oob_illegal();
        test_clear_interaction();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Byte-addressed, parametrised data memory for the single-cycle RISC-V core, serving the LB/LH/LW/LBU/LHU/SB/SH/SW access types selected by the instruction funct3 field. Reads are combinational and writes are synchronous. It replaces the old reset-time array wipe with a sequential clear engine, and adds alignment and range checking with a sticky fault record. It sits between the ALU result/rs2 datapath and the writeback mux.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; must be a power of two, minimum 4.
ADDR_WIDTH, 32, width of the byte address input.
CLEAR_ON_RESET, 1, 1 = zero all words sequentially after reset; 0 = skip the clear and keep contents.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
addr  input  ADDR_WIDTH  byte address.
re  input  1  load request.
we  input  1  store request.
funct3  input  3  access size and sign mode.
wd  input  32  store data; the low byte or halfword is used for SB/SH.
rd  output  32  load data, extended as funct3 requires.
busy  output  1  clear sweep in progress.
misaligned  output  1  combinational alignment violation on the current access.
fault  output  1  sticky error flag.
fault_addr  output  ADDR_WIDTH  address of the first faulting access.

Behaviour:
- Reset (rst low, asynchronous):
  - fault=0, fault_addr=0, clr_idx=0.
  - state=CLEAR if CLEAR_ON_RESET=1, else READY.
  - Array contents are not touched asynchronously.
- FSM, two states:
  - CLEAR: each rising edge writes 0 to mem[clr_idx] and increments clr_idx. When clr_idx==DEPTH_WORDS-1, that word is written and the next state is READY.
  - READY: terminal until the next reset.
  - The clear takes exactly DEPTH_WORDS cycles after rst releases.
- busy = (state==CLEAR). While busy:
  - rd=0, stores are ignored, fault is not updated.
  - misaligned is still computed.
- Reset mid-clear: the sweep restarts at index 0.
- Address decode:
  - word index = addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0]; little-endian.
  - oob = (addr>>2) >= DEPTH_WORDS.
- funct3 encoding:
  - 000 byte signed, 100 byte unsigned.
  - 001 half signed, 101 half unsigned.
  - 010 word.
  - 011, 110 and 111 are illegal.
  - For stores only 000/001/010 are legal.
- misaligned = (re|we) & ((half & addr[0]) | (word & addr[1:0]!=0)).
- err = misaligned | oob | illegal funct3, qualified by re|we.
- Load (combinational):
  - rd is the selected byte/half/word, sign- or zero-extended to 32 bits.
  - rd=0 when err, busy, or re=0.
- Store, on the rising edge when we & ~busy & ~err:
  - Only the addressed byte lanes are written; other lanes are unchanged.
  - A store with err is dropped entirely.
- Same-cycle read of a word being written returns the old contents; new data is visible the next cycle.
- re and we both high is legal: rd shows the old data, the store commits at the edge.
- Fault capture: at an edge in READY with err, if fault==0 then fault<=1 and fault_addr<=addr. Later errors do not overwrite the record; only reset clears it.

Test Plan:
- DEPTH_WORDS=16, release rst -> busy high for exactly 16 cycles, then low; LW 0x3C -> 0x00000000. Preload mem[0]=0xFFFFFFFF via backdoor before reset -> reads 0 after the clear.
- SW 0x800080F0 @0x10 -> LB 0x10 = 0xFFFFFFF0; LBU 0x11 = 0x00000080; LH 0x12 = 0xFFFF8000; LHU 0x10 = 0x000080F0; LW 0x10 = 0x800080F0.
- SB 0x123456AB @0x13, then SH 0x0000BEEF @0x14 -> LW 0x10 = 0xAB0080F0; LW 0x14 = 0x0000BEEF.
- SW @0x22 -> misaligned=1 that cycle, no write (LW 0x20 unchanged), fault=1, fault_addr=0x22. A following LH @0x31 -> fault_addr stays 0x22.
- SW @0x40 (oob, DEPTH 16) and funct3=011 load -> rd=0, no array change, fault set.
- SW 0x55 @0x00 at clear cycle 3 -> ignored, word reads 0 after the clear. Pulse rst low at clear cycle 8 -> busy lasts 16 more cycles after release.
